breath_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the single-LED PWM breathing datapath.
//  - Accepts ramp segments {target duty, step, hold} over valid/ready into a small FIFO.
//  - Executes the segments one at a time, moving the duty register once per PWM period.
//  - Drives the LED output of the PWM comparator.
//  - Replaces the free-running triangle ramp; the host CPU/FSM schedules the breathing profile.

---
 rtl/breath_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_breath_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breath_seq_ctrl.sv
// breath_seq_ctrl: queued ramp segments {target, step, hold} drive a one-LED PWM duty once per period.
// Latency: an accepted command is popped the next cycle when idle; duty and hold advance only on the period tick.
// Backpressure: cmd_ready = !full; with BREATH_SEQ_LOOP_EN defined it also drops in a loop re-push cycle.

module breath_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop_rdy && !empty && !flush;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push  = push_vld && (!full || do_pop) && !flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module breath_seq_ctrl #(
    parameter int PERIOD_MAX = 50000,
    parameter int DUTY_W     = 16,
    parameter int HOLD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DUTY_W-1:0]           cmd_target,
    input  logic [DUTY_W-1:0]           cmd_step,
    input  logic [HOLD_W-1:0]           cmd_hold,
    input  logic                        abort,
`ifdef BREATH_SEQ_LOOP_EN
    input  logic                        loop,
`endif
    output logic                        busy,
    output logic                        seg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [DUTY_W-1:0]           duty_cycle,
    output logic                        led
);
    typedef struct packed {
        logic [DUTY_W-1:0] target;
        logic [DUTY_W-1:0] step;
        logic [HOLD_W-1:0] hold;
    } seg_t;

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    localparam logic [DUTY_W-1:0] PMAX = DUTY_W'(PERIOD_MAX);

    logic [DUTY_W-1:0] period_cnt;
    logic              tick;
    state_t            state_q, state_d;
    seg_t              seg_q, seg_d, cmd_seg, head, head_san, push_seg;
    logic [DUTY_W-1:0] duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DUTY_W:0]   up_diff, dn_diff;
    logic              push, pop, full, empty, repush;

    assign tick = (period_cnt == PMAX);
    assign led  = (period_cnt >= duty_cycle);
    assign busy = (state_q != IDLE) || !empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  period_cnt <= '0;
        else if (tick)   period_cnt <= '0;
        else             period_cnt <= period_cnt + DUTY_W'(1);
    end

`ifdef BREATH_SEQ_LOOP_EN
    assign repush = seg_done && loop;
`else
    assign repush = 1'b0;
`endif

    // The completing segment re-enters the tail ahead of any host command.
    assign cmd_ready = !full && !repush;
    assign cmd_seg   = {cmd_target, cmd_step, cmd_hold};
    assign push      = repush || (cmd_valid && cmd_ready && !abort);
    assign push_seg  = repush ? seg_q : cmd_seg;

    breath_seq_fifo #(
        .WIDTH ($bits(seg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flush     (abort),
        .push_vld  (push),
        .push_dat  (push_seg),
        .pop_rdy   (pop),
        .head_dat  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_comb begin
        head_san = head;
        if (head.target > PMAX) head_san.target = PMAX;
        if (head.step == '0)    head_san.step   = DUTY_W'(1);
    end

    // One extra bit keeps the distance compare free of wrap at either end.
    assign up_diff = {1'b0, seg_q.target} - {1'b0, duty_cycle};
    assign dn_diff = {1'b0, duty_cycle} - {1'b0, seg_q.target};

    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        duty_d   = duty_cycle;
        hold_d   = hold_q;
        pop      = 1'b0;
        seg_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    seg_d   = head_san;
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (tick) begin
                    if (duty_cycle == seg_q.target) begin
                        state_d = HOLD;
                        hold_d  = seg_q.hold;
                    end else if (seg_q.target > duty_cycle) begin
                        duty_d = (up_diff <= {1'b0, seg_q.step}) ? seg_q.target
                                                                 : duty_cycle + seg_q.step;
                    end else begin
                        duty_d = (dn_diff <= {1'b0, seg_q.step}) ? seg_q.target
                                                                 : duty_cycle - seg_q.step;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_q == '0) begin
                        seg_done = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            seg_d   = head_san;
                            state_d = RAMP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            duty_d   = duty_cycle;
            pop      = 1'b0;
            seg_done = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            seg_q      <= '0;
            duty_cycle <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            duty_cycle <= duty_d;
            hold_q     <= hold_d;
        end
    end
endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Directed bench for breath_seq_ctrl with a 10-cycle PWM period.
module tb_breath_seq_ctrl;
    localparam int PM = 9;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_target;
    logic [15:0] cmd_step;
    logic [15:0] cmd_hold;
    logic        abort;
`ifdef BREATH_SEQ_LOOP_EN
    logic        loop;
`endif
    logic        busy;
    logic        seg_done;
    logic [2:0]  fifo_level;
    logic [15:0] duty_cycle;
    logic        led;

    int checks = 0;
    int failures = 0;
    int ph;

    breath_seq_ctrl #(
        .PERIOD_MAX (PM),
        .DUTY_W     (16),
        .HOLD_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
`ifdef BREATH_SEQ_LOOP_EN
        .loop       (loop),
`endif
        .busy       (busy),
        .seg_done   (seg_done),
        .fifo_level (fifo_level),
        .duty_cycle (duty_cycle),
        .led        (led)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Phase of the PWM period, tracked independently from reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ph <= 0;
        else            ph <= (ph == PM) ? 0 : ph + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] target;
        logic [15:0] step;
        logic [15:0] hold;
        int          exp_ticks;
        logic [15:0] exp_duty;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [15:0] t, input logic [15:0] s,
                           input logic [15:0] h);
        cmd_valid  = v;
        cmd_target = t;
        cmd_step   = s;
        cmd_hold   = h;
    endtask

    task automatic wait_ph(input int p);
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (ph == p) return;
        end
        check("wait_phase", ph, p);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    vec_t        vecs[7];
    logic [15:0] traj[8];
    logic [15:0] ltraj[10];
    int          ticks, dones, gap, low, maxlvl;
    int          done_tick[2];
    bit          got;
    logic [15:0] duty_before;

    initial begin
        sys_rst_n = 1'b0;
        abort     = 1'b0;
`ifdef BREATH_SEQ_LOOP_EN
        loop      = 1'b0;
`endif
        set_cmd(1'b0, 16'd0, 16'd0, 16'd0);

        vecs[0] = '{16'd6,  16'd2,     16'd1, 6,  16'd6};
        vecs[1] = '{16'd6,  16'd4,     16'd0, 2,  16'd6};
        vecs[2] = '{16'd1,  16'd4,     16'd0, 4,  16'd1};
        vecs[3] = '{16'd50, 16'd0,     16'd0, 10, 16'd9};
        vecs[4] = '{16'd0,  16'd65535, 16'd2, 5,  16'd0};
        vecs[5] = '{16'd9,  16'd10,    16'd0, 3,  16'd9};
        vecs[6] = '{16'd3,  16'd3,     16'd0, 4,  16'd3};

        // Reset values
        #2;
        check("rst_duty", duty_cycle, 0);
        check("rst_led", led, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_done", seg_done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            check("idle_led", led, 1);
            check("idle_busy", busy, 0);
        end
        check("idle_duty", duty_cycle, 0);
        check("idle_ready", cmd_ready, 1);

        // Table: one segment at a time, duty carried from the previous row
        for (int i = 0; i < 7; i++) begin
            wait_ph(0);
            set_cmd(1'b1, vecs[i].target, vecs[i].step, vecs[i].hold);
            @(negedge sys_clk);
            cmd_valid = 1'b0;
            ticks = 0;
            got = 0;
            for (int c = 0; c < 400; c++) begin
                if (ph == PM) ticks++;
                if (seg_done) begin
                    got = 1;
                    break;
                end
                @(negedge sys_clk);
            end
            check($sformatf("vec%0d_done", i), got, 1);
            check($sformatf("vec%0d_ticks", i), ticks, vecs[i].exp_ticks);
            check($sformatf("vec%0d_duty", i), duty_cycle, vecs[i].exp_duty);
            @(negedge sys_clk);
            check($sformatf("vec%0d_idle", i), busy, 0);
            check($sformatf("vec%0d_pulse", i), seg_done, 0);
        end

        // PWM shape at duty 3
        wait_ph(0);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            if (!led) low++;
            @(negedge sys_clk);
        end
        check("led_low_cycles", low, 3);

        // Reset mid-segment returns everything at once
        set_cmd(1'b1, 16'd9, 16'd1, 16'd5);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (25) @(negedge sys_clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_duty_moved", duty_cycle != 3, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_duty", duty_cycle, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_led", led, 1);
        check("async_rst_level", fifo_level, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Two queued segments run without an idle gap
        traj = '{16'd4, 16'd6, 16'd6, 16'd6, 16'd2, 16'd1, 16'd1, 16'd1};
        wait_ph(0);
        set_cmd(1'b1, 16'd6, 16'd4, 16'd0);
        @(negedge sys_clk);
        set_cmd(1'b1, 16'd1, 16'd4, 16'd0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        ticks = 0;
        dones = 0;
        gap = 0;
        done_tick[0] = 0;
        done_tick[1] = 0;
        for (int c = 0; c < 150; c++) begin
            if (ph == PM) begin
                ticks++;
                if (seg_done) begin
                    if (dones < 2) done_tick[dones] = ticks;
                    dones++;
                end
            end
            if (ph == 0 && ticks > 0) begin
                check($sformatf("pair_duty_t%0d", ticks), duty_cycle, traj[ticks-1]);
                if (ticks == 8) break;
            end
            if (!busy) gap++;
            @(negedge sys_clk);
        end
        check("pair_ticks", ticks, 8);
        check("pair_dones", dones, 2);
        check("pair_done1_tick", done_tick[0], 4);
        check("pair_done2_tick", done_tick[1], 8);
        check("pair_idle_gap", gap, 0);
        check("pair_end_idle", busy, 0);

        // Fill the FIFO behind a running segment, then abort
        do_reset();
        set_cmd(1'b1, 16'd9, 16'd1, 16'd0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        check("fill_popped", fifo_level, 0);
        check("fill_busy", busy, 1);
        for (int c = 0; c < 100; c++) begin
            if (duty_cycle == 3) break;
            @(negedge sys_clk);
        end
        check("fill_duty_start", duty_cycle, 3);
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 16'(i + 1), 16'd1, 16'd0);
            check($sformatf("fill_ready%0d", i), cmd_ready, (i < 4) ? 1 : 0);
            @(negedge sys_clk);
        end
        check("full_level", fifo_level, 4);
        check("full_ready", cmd_ready, 0);
        duty_before = duty_cycle;
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        cmd_valid = 1'b0;
        check("abort_level", fifo_level, 0);
        check("abort_busy", busy, 0);
        check("abort_duty", duty_cycle, duty_before);
        check("abort_ready", cmd_ready, 1);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge sys_clk);
            if (seg_done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_duty_frozen", duty_cycle, duty_before);

        set_cmd(1'b1, 16'd7, 16'd1, 16'd0);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        cmd_valid = 1'b0;
        check("abort_push_level", fifo_level, 0);
        check("abort_push_busy", busy, 0);
        @(negedge sys_clk);
        check("abort_push_still_idle", busy, 0);

        // Period counter keeps its phase through abort
        wait_ph(0);
        check("phase_led_p0", led, 0);
        wait_ph(2);
        check("phase_led_p2", led, 0);
        @(negedge sys_clk);
        check("phase_led_p3", led, 1);

`ifdef BREATH_SEQ_LOOP_EN
        // Looping profile 0->9->0
        ltraj = '{16'd3, 16'd6, 16'd9, 16'd9, 16'd9, 16'd6, 16'd3, 16'd0, 16'd0, 16'd0};
        do_reset();
        loop = 1'b1;
        wait_ph(0);
        set_cmd(1'b1, 16'd9, 16'd3, 16'd0);
        @(negedge sys_clk);
        set_cmd(1'b1, 16'd0, 16'd3, 16'd0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        ticks = 0;
        maxlvl = 0;
        for (int c = 0; c < 300; c++) begin
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (ph == PM) ticks++;
            if (ph == 0 && ticks > 0) begin
                check($sformatf("loop_duty_t%0d", ticks), duty_cycle, ltraj[(ticks-1) % 10]);
                if (ticks == 25) break;
            end
            @(negedge sys_clk);
        end
        check("loop_ticks", ticks, 25);
        check("loop_max_level", maxlvl <= 2, 1);
        loop = 1'b0;
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("loop_abort_level", fifo_level, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
